eos_mq_sched: RTL

- Parametrised egress output scheduler for the TSN switch.
- Sits between IBM (metadata in) and EBM (metadata out), with UDO FIFO-level backpressure.
- Generalises the 4-queue egress scheduler to NQ queues: queues 0/1 form the CQF ping-pong pair, queue 2 is rate-constrained behind a token bucket, and queues 3..NQ-1 are strict-priority best-effort.
- Adds CQF residual flush, a saturating token bucket, a dispatch/complete handshake and drop/flush statistics.

---
 rtl/eos_mq_sched_if.sv | 54 +++++
 rtl/eos_mq_sched.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/eos_mq_sched_if.sv
// rtl/eos_mq_sched_if.sv - metadata, control and statistics bundle for eos_mq_sched
//   in_md_*            : metadata write from IBM (wr strobe, bufid, len, type, pri)
//   in_time_slot_flag  : CQF slot boundary pulse
//   in_rate_inc/max    : token bucket refill rate and ceiling
//   in_pktout_usedw    : UDO FIFO level (backpressure)
//   in_pkt_done        : EBM completion pulse
//   out_md_*           : dispatch strobe, buffer id and length
//   out_q_used         : per-queue occupancy, queue 0 in the LSBs
//   out_cqf_slot       : current CQF write-queue index
//   out_*_cnt          : enqueue, dispatch, drop and flush statistics
interface eos_mq_sched_if #(
  parameter int NQ     = 8,
  parameter int QDEPTH = 16,
  parameter int MD_W   = 8,
  parameter int LEN_W  = 11,
  parameter int TOK_W  = 32
) ();
  localparam int QW = $clog2(QDEPTH) + 1;

  logic                 in_md_wr;
  logic [MD_W-1:0]      in_md_bufid;
  logic [LEN_W-1:0]     in_md_len;
  logic [1:0]           in_md_type;
  logic [3:0]           in_md_pri;
  logic                 in_time_slot_flag;
  logic [TOK_W-1:0]     in_rate_inc;
  logic [TOK_W-1:0]     in_bucket_max;
  logic [7:0]           in_pktout_usedw;
  logic                 in_pkt_done;

  logic                 out_md_wr;
  logic [MD_W-1:0]      out_md;
  logic [LEN_W-1:0]     out_md_len;
  logic [NQ*QW-1:0]     out_q_used;
  logic                 out_cqf_slot;
  logic [63:0]          out_mdin_cnt;
  logic [63:0]          out_mdout_cnt;
  logic [31:0]          out_drop_cnt;
  logic [31:0]          out_flush_cnt;

  modport master (
    output in_md_wr, in_md_bufid, in_md_len, in_md_type, in_md_pri,
           in_time_slot_flag, in_rate_inc, in_bucket_max, in_pktout_usedw, in_pkt_done,
    input  out_md_wr, out_md, out_md_len, out_q_used, out_cqf_slot,
           out_mdin_cnt, out_mdout_cnt, out_drop_cnt, out_flush_cnt
  );

  modport slave (
    input  in_md_wr, in_md_bufid, in_md_len, in_md_type, in_md_pri,
           in_time_slot_flag, in_rate_inc, in_bucket_max, in_pktout_usedw, in_pkt_done,
    output out_md_wr, out_md, out_md_len, out_q_used, out_cqf_slot,
           out_mdin_cnt, out_mdout_cnt, out_drop_cnt, out_flush_cnt
  );
endinterface

// File: rtl/eos_mq_sched.sv
// rtl/eos_mq_sched.sv - NQ-queue egress scheduler: CQF pair, token-bucket RC, strict-priority BE
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : eos_mq_sched_if slave (metadata in, dispatch out, statistics)
module eos_mq_sched #(
  parameter int         NQ      = 8,
  parameter int         QDEPTH  = 16,
  parameter int         MD_W    = 8,
  parameter int         LEN_W   = 11,
  parameter int         TOK_W   = 32,
  parameter logic [7:0] HIGH_WM = 8'd200
) (
  input  logic          clk,
  input  logic          rst,
  eos_mq_sched_if.slave bus
);
  localparam int AW  = $clog2(QDEPTH);
  localparam int QW  = AW + 1;
  localparam int QIW = $clog2(NQ);
  localparam int EW  = MD_W + LEN_W;

  typedef enum logic [1:0] {ST_ARB, ST_ISSUE, ST_WAIT} state_t;
  state_t state, state_next;

  // Entry layout: {bufid, len}
  logic [EW-1:0]    mem    [NQ][QDEPTH];
  logic [QW-1:0]    wr_ptr [NQ];
  logic [QW-1:0]    rd_ptr [NQ];
  logic [QW-1:0]    used   [NQ];
  logic [EW-1:0]    head   [NQ];

  logic             slot;
  logic [TOK_W-1:0] tok, tok_next;
  logic [MD_W-1:0]  md_r;
  logic [LEN_W-1:0] len_r;
  logic [63:0]      mdin_cnt, mdout_cnt;
  logic [31:0]      drop_cnt, flush_cnt;
  logic [NQ*QW-1:0] q_used_flat;

  // Pointers carry one extra bit so full and empty are distinguishable.
  always_comb begin
    for (int q = 0; q < NQ; q++) begin
      used[q] = wr_ptr[q] - rd_ptr[q];
      head[q] = mem[q][rd_ptr[q][AW-1:0]];
      q_used_flat[q*QW +: QW] = used[q];
    end
  end

  // Enqueue target selection and full check against start-of-cycle occupancy.
  logic [QIW-1:0] enq_q;
  logic           enq_type_ok, enq_ok, enq_drop;

  always_comb begin
    enq_q       = '0;
    enq_type_ok = 1'b1;
    case (bus.in_md_type)
      2'b00:   enq_q = QIW'(slot);
      2'b01:   enq_q = QIW'(2);
      2'b10:   enq_q = (int'(bus.in_md_pri) > NQ - 4) ? QIW'(NQ - 1)
                                                      : QIW'(3 + int'(bus.in_md_pri));
      default: enq_type_ok = 1'b0;
    endcase
    enq_ok   = bus.in_md_wr && enq_type_ok && (used[enq_q] != QW'(QDEPTH));
    enq_drop = bus.in_md_wr && !enq_ok;
  end

  // The TX queue of the CQF pair is the one not currently being written.
  logic           tx_sel;
  logic [QIW-1:0] tx_q;
  assign tx_sel = ~slot;
  assign tx_q   = QIW'(tx_sel);

  logic [TOK_W-1:0] rc_len;
  logic             rc_elig;
  assign rc_len  = TOK_W'(head[2][LEN_W-1:0]);
  assign rc_elig = (used[2] != '0) && (tok >= rc_len);

  logic           be_any;
  logic [QIW-1:0] be_q;
  always_comb begin
    be_any = 1'b0;
    be_q   = '0;
    // Ascending scan: the last non-empty hit is the highest priority.
    for (int q = 3; q < NQ; q++) begin
      if (used[q] != '0) begin
        be_any = 1'b1;
        be_q   = QIW'(q);
      end
    end
  end

  logic           can_arb, pop;
  logic [QIW-1:0] pop_q;
  assign can_arb = (bus.in_pktout_usedw < HIGH_WM) && !bus.in_time_slot_flag;

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    pop_q      = '0;
    case (state)
      ST_ARB: begin
        if (can_arb) begin
          if (used[tx_q] != '0) begin
            pop   = 1'b1;
            pop_q = tx_q;
          end else if (rc_elig) begin
            pop   = 1'b1;
            pop_q = QIW'(2);
          end else if (be_any) begin
            pop   = 1'b1;
            pop_q = be_q;
          end
          if (pop) state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT:  if (bus.in_pkt_done) state_next = ST_ARB;
      default:  state_next = ST_ARB;
    endcase
  end

  // Token bucket in TOK_W+1 bits: the pop never exceeds tok, so only the
  // refill can overflow TOK_W, and the ceiling clamps it back.
  logic [TOK_W-1:0] popped_len;
  logic [TOK_W:0]   tok_sum;
  always_comb begin
    popped_len = (pop && (pop_q == QIW'(2))) ? rc_len : '0;
    tok_sum    = {1'b0, tok} - {1'b0, popped_len} + {1'b0, bus.in_rate_inc};
    tok_next   = (tok_sum > {1'b0, bus.in_bucket_max}) ? bus.in_bucket_max
                                                      : tok_sum[TOK_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_ARB;
      slot      <= 1'b0;
      tok       <= '0;
      md_r      <= '0;
      len_r     <= '0;
      mdin_cnt  <= '0;
      mdout_cnt <= '0;
      drop_cnt  <= '0;
      flush_cnt <= '0;
      for (int q = 0; q < NQ; q++) begin
        wr_ptr[q] <= '0;
        rd_ptr[q] <= '0;
      end
    end else begin
      state <= state_next;
      tok   <= tok_next;
      if (bus.in_time_slot_flag) begin
        slot      <= ~slot;
        flush_cnt <= flush_cnt + 32'(used[tx_q]);
      end
      // No pop happens on a slot pulse, and a TS enqueue that cycle targets
      // the old write queue, so flushing the TX queue loses nothing in flight.
      for (int q = 0; q < NQ; q++) begin
        if (bus.in_time_slot_flag && (tx_q == QIW'(q))) begin
          wr_ptr[q] <= '0;
          rd_ptr[q] <= '0;
        end else begin
          if (enq_ok && (enq_q == QIW'(q))) wr_ptr[q] <= wr_ptr[q] + QW'(1);
          if (pop && (pop_q == QIW'(q)))    rd_ptr[q] <= rd_ptr[q] + QW'(1);
        end
      end
      if (pop) begin
        md_r  <= head[pop_q][EW-1:LEN_W];
        len_r <= head[pop_q][LEN_W-1:0];
      end
      if (enq_ok)             mdin_cnt  <= mdin_cnt + 64'd1;
      if (enq_drop)           drop_cnt  <= drop_cnt + 32'd1;
      if (state == ST_ISSUE)  mdout_cnt <= mdout_cnt + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_ok) mem[enq_q][wr_ptr[enq_q][AW-1:0]] <= {bus.in_md_bufid, bus.in_md_len};
  end

  assign bus.out_md_wr     = (state == ST_ISSUE);
  assign bus.out_md        = md_r;
  assign bus.out_md_len    = len_r;
  assign bus.out_q_used    = q_used_flat;
  assign bus.out_cqf_slot  = slot;
  assign bus.out_mdin_cnt  = mdin_cnt;
  assign bus.out_mdout_cnt = mdout_cnt;
  assign bus.out_drop_cnt  = drop_cnt;
  assign bus.out_flush_cnt = flush_cnt;
endmodule
